// File: rtl/eth_tx_port_sched.sv
// Per-port TX scheduler: descriptor FIFO, arbiter req/ack handshake, header hold,
// inter-frame gap enforcement, frame counter and worst-case grant latency.
module eth_tx_port_sched #(
  parameter int          DEPTH      = 4,
  parameter int          IFG_CYCLES = 12,
  parameter logic [23:0] MAC_MSB    = 24'h010203,
  parameter logic [23:0] MAC_LSB    = 24'h040506
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic [47:0]              desc_dst_mac,
  input  logic [15:0]              desc_ethertype,
  output logic                     port_req,
  input  logic                     port_ack,
  output logic [47:0]              port_dst_mac,
  output logic [47:0]              port_src_mac,
  output logic [15:0]              port_ethertype,
  input  logic                     mon_tvalid,
  input  logic                     mon_tready,
  input  logic                     mon_tlast,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_level,
  output logic [31:0]              frames_sent,
  output logic [15:0]              max_grant_lat
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
  localparam logic [15:0]   GAP_LAST = 16'((IFG_CYCLES == 0) ? 0 : IFG_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_GAP} state_t;

  state_t      r_state, w_next;
  logic        r_req;
  logic [47:0] r_mac_mem  [DEPTH];
  logic [15:0] r_type_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_level;
  logic [47:0] r_dst;
  logic [15:0] r_type;
  logic [15:0] r_lat_cnt, r_max_lat, r_gap_cnt;
  logic [31:0] r_frames_sent;

  logic        w_push, w_pop, w_latch, w_frame_done, w_tlast_hs, w_gap_done;
  logic [15:0] w_lat_new;

  assign desc_ready  = (r_level != FULL);
  assign w_push      = desc_valid && desc_ready;
  assign w_tlast_hs  = mon_tvalid && mon_tready && mon_tlast;
  assign w_gap_done  = (r_gap_cnt == GAP_LAST);
  assign w_lat_new   = (r_lat_cnt == 16'hFFFF) ? 16'hFFFF : r_lat_cnt + 16'd1;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_req   <= (w_next == S_REQ);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (r_level != '0) w_next = S_REQ;
      S_REQ:  if (port_ack)      w_next = S_BUSY;
      S_BUSY: if (w_tlast_hs)    w_next = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (w_gap_done)    w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (r_state != S_IDLE);
    w_latch      = (r_state == S_IDLE) && (r_level != '0);
    w_pop        = (r_state == S_REQ) && port_ack;
    w_frame_done = (r_state == S_BUSY) && w_tlast_hs;
  end

  // Storage array carries no reset; only pointers and level define contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mac_mem[r_wptr]  <= desc_dst_mac;
      r_type_mem[r_wptr] <= desc_ethertype;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_dst         <= '0;
      r_type        <= '0;
      r_lat_cnt     <= '0;
      r_max_lat     <= '0;
      r_gap_cnt     <= '0;
      r_frames_sent <= '0;
    end else begin
      if (w_latch) begin
        r_dst  <= r_mac_mem[r_rptr];
        r_type <= r_type_mem[r_rptr];
      end
      // Latency counts REQ cycles, so an ack in the first REQ cycle scores 1.
      if (r_state == S_REQ) r_lat_cnt <= w_lat_new;
      else                  r_lat_cnt <= '0;
      if (w_pop && (w_lat_new > r_max_lat)) r_max_lat <= w_lat_new;
      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 16'd1;
      else                  r_gap_cnt <= '0;
      if (w_frame_done) r_frames_sent <= r_frames_sent + 32'd1;
    end
  end

  assign port_req       = r_req;
  assign port_dst_mac   = r_dst;
  assign port_src_mac   = {MAC_MSB, MAC_LSB};
  assign port_ethertype = r_type;
  assign queue_level    = r_level;
  assign frames_sent    = r_frames_sent;
  assign max_grant_lat  = r_max_lat;
endmodule

// File: tb/tb_eth_tx_port_sched.sv
// Directed bench for eth_tx_port_sched: one instance with the default gap,
// one with IFG_CYCLES=0; sel picks which one the checks look at.
module tb_eth_tx_port_sched;
  logic clk = 1'b0, areset = 1'b1;
  always #5 clk = ~clk;

  logic        desc_valid = 1'b0;
  logic [47:0] desc_dst_mac = '0;
  logic [15:0] desc_ethertype = '0;
  logic        port_ack = 1'b0, mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;

  logic        a_ready, a_req, a_busy, b_ready, b_req, b_busy;
  logic [47:0] a_dst, a_src, b_dst, b_src;
  logic [15:0] a_type, b_type, a_lat, b_lat;
  logic [2:0]  a_lvl, b_lvl;
  logic [31:0] a_frm, b_frm;

  eth_tx_port_sched dut (
    .clk(clk), .areset(areset), .desc_valid(desc_valid), .desc_ready(a_ready),
    .desc_dst_mac(desc_dst_mac), .desc_ethertype(desc_ethertype),
    .port_req(a_req), .port_ack(port_ack), .port_dst_mac(a_dst), .port_src_mac(a_src),
    .port_ethertype(a_type), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .mon_tlast(mon_tlast), .busy(a_busy), .queue_level(a_lvl), .frames_sent(a_frm),
    .max_grant_lat(a_lat));

  eth_tx_port_sched #(.IFG_CYCLES(0)) dut0 (
    .clk(clk), .areset(areset), .desc_valid(desc_valid), .desc_ready(b_ready),
    .desc_dst_mac(desc_dst_mac), .desc_ethertype(desc_ethertype),
    .port_req(b_req), .port_ack(port_ack), .port_dst_mac(b_dst), .port_src_mac(b_src),
    .port_ethertype(b_type), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .mon_tlast(mon_tlast), .busy(b_busy), .queue_level(b_lvl), .frames_sent(b_frm),
    .max_grant_lat(b_lat));

  logic        sel = 1'b0;
  logic        ready, req, busy;
  logic [47:0] dst, src;
  logic [15:0] typ, lat;
  logic [2:0]  lvl;
  logic [31:0] frm;
  assign ready = sel ? b_ready : a_ready;
  assign req   = sel ? b_req   : a_req;
  assign busy  = sel ? b_busy  : a_busy;
  assign dst   = sel ? b_dst   : a_dst;
  assign src   = sel ? b_src   : a_src;
  assign typ   = sel ? b_type  : a_type;
  assign lat   = sel ? b_lat   : a_lat;
  assign lvl   = sel ? b_lvl   : a_lvl;
  assign frm   = sel ? b_frm   : a_frm;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    areset = 1'b1; #3; areset = 1'b0;
    tick();
  endtask

  task automatic push(input logic [47:0] d, input logic [15:0] t);
    desc_valid = 1'b1; desc_dst_mac = d; desc_ethertype = t;
    tick();
    desc_valid = 1'b0;
  endtask

  // Waits for req, acks it on its dly-th cycle, then sends a two-beat payload.
  task automatic run_frame(input logic [47:0] edst, input logic [15:0] etyp, input int dly,
                           input logic [2:0] elvl, input logic [31:0] efrm, output int waited);
    waited = 0;
    while (!req && waited < 200) begin tick(); waited++; end
    chk("req_seen", {63'd0, req}, 64'd1);
    if (!req) return;
    chk("hdr_dst_at_req", dst, edst);
    chk("hdr_type_at_req", typ, etyp);
    repeat (dly - 1) tick();
    chk("req_held", {63'd0, req}, 64'd1);
    port_ack = 1'b1; tick(); port_ack = 1'b0;
    chk("req_drop_after_ack", {63'd0, req}, 64'd0);
    chk("level_after_pop", lvl, elvl);
    mon_tvalid = 1'b1; mon_tready = 1'b1; tick();
    mon_tlast = 1'b1; tick();
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    chk("hdr_dst_at_tlast", dst, edst);
    chk("hdr_type_at_tlast", typ, etyp);
    chk("frames_after_tlast", frm, efrm);
  endtask

  typedef struct {
    logic push, ack, tv, tl;
    logic req, busy;
    logic [2:0] lvl;
    logic [31:0] frm;
    logic [15:0] lat;
    logic hdr;
  } vec_t;

  function automatic vec_t mk(input logic push, ack, tv, tl, req, bsy, input logic [2:0] lvl,
                              input logic [31:0] frm, input logic [15:0] lat, input logic hdr);
    vec_t v;
    v.push = push; v.ack = ack; v.tv = tv; v.tl = tl; v.req = req; v.busy = bsy;
    v.lvl = lvl; v.frm = frm; v.lat = lat; v.hdr = hdr;
    return v;
  endfunction

  initial begin
    vec_t vt[20];
    int w;
    logic [47:0] edst;

    vt[0] = mk(1,0,0,0, 0,0, 1, 0, 0, 0);
    vt[1] = mk(0,0,0,0, 1,1, 1, 0, 0, 1);
    vt[2] = mk(0,0,0,0, 1,1, 1, 0, 0, 1);
    vt[3] = mk(0,0,0,0, 1,1, 1, 0, 0, 1);
    vt[4] = mk(0,1,0,0, 0,1, 0, 0, 3, 1);
    vt[5] = mk(0,0,1,0, 0,1, 0, 0, 3, 1);
    vt[6] = mk(0,0,1,1, 0,1, 0, 1, 3, 1);
    for (int i = 7; i <= 17; i++) vt[i] = mk(0,0,0,0, 0,1, 0, 1, 3, 1);
    vt[18] = mk(0,0,0,0, 0,0, 0, 1, 3, 1);
    vt[19] = mk(0,0,0,0, 0,0, 0, 1, 3, 1);

    // Reset values
    tick(); tick();
    chk("rst_req", {63'd0, req}, 0);
    chk("rst_busy", {63'd0, busy}, 0);
    chk("rst_level", lvl, 0);
    chk("rst_frames", frm, 0);
    chk("rst_lat", lat, 0);
    chk("rst_dst", dst, 0);
    chk("rst_type", typ, 0);
    chk("rst_ready", {63'd0, ready}, 1);
    chk("src_mac", src, 48'h010203040506);
    areset = 1'b0;
    tick();

    // Single frame, cycle by cycle
    for (int i = 0; i < 20; i++) begin
      desc_valid = vt[i].push; desc_dst_mac = 48'hAABBCCDDEEFF; desc_ethertype = 16'h0800;
      port_ack = vt[i].ack; mon_tvalid = vt[i].tv; mon_tready = vt[i].tv; mon_tlast = vt[i].tl;
      tick();
      desc_valid = 1'b0; port_ack = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
      edst = vt[i].hdr ? 48'hAABBCCDDEEFF : 48'h0;
      chk($sformatf("t1_req[%0d]", i), {63'd0, req}, {63'd0, vt[i].req});
      chk($sformatf("t1_busy[%0d]", i), {63'd0, busy}, {63'd0, vt[i].busy});
      chk($sformatf("t1_level[%0d]", i), lvl, vt[i].lvl);
      chk($sformatf("t1_frames[%0d]", i), frm, vt[i].frm);
      chk($sformatf("t1_lat[%0d]", i), lat, vt[i].lat);
      chk($sformatf("t1_dst[%0d]", i), dst, edst);
      chk($sformatf("t1_type[%0d]", i), typ, vt[i].hdr ? 16'h0800 : 16'h0);
    end

    // Fill the queue, overflow push ignored, drain in order with full gaps
    do_reset();
    for (int k = 0; k < 4; k++) push(48'h0000_0000_0010 + 48'(k), 16'h0800 + 16'(k));
    chk("full_ready", {63'd0, ready}, 0);
    chk("full_level", lvl, 4);
    push(48'hDEAD_DEAD_DEAD, 16'hDEAD);
    chk("overflow_level", lvl, 4);
    for (int k = 0; k < 4; k++) begin
      run_frame(48'h0000_0000_0010 + 48'(k), 16'h0800 + 16'(k), 2, 3'(3 - k), 32'(k + 1), w);
      if (k > 0) chk("ifg_gap_cycles", w, 13);
    end
    repeat (40) tick();
    chk("drained_req", {63'd0, req}, 0);
    chk("drained_busy", {63'd0, busy}, 0);
    chk("drained_level", lvl, 0);
    chk("drained_frames", frm, 4);

    // Zero gap instance, ack in first req cycle
    sel = 1'b1;
    do_reset();
    push(48'h1111_2222_3333, 16'h0806);
    push(48'h4444_5555_6666, 16'h86DD);
    run_frame(48'h1111_2222_3333, 16'h0806, 1, 1, 1, w);
    run_frame(48'h4444_5555_6666, 16'h86DD, 1, 0, 2, w);
    chk("ifg0_gap_cycles", w, 1);
    chk("ifg0_lat", lat, 1);
    sel = 1'b0;

    // Push and pop in the same cycle at level 2
    do_reset();
    push(48'hA0A0_A0A0_A0A0, 16'h0001);
    push(48'hB0B0_B0B0_B0B0, 16'h0002);
    chk("pp_req_before", {63'd0, req}, 1);
    desc_valid = 1'b1; desc_dst_mac = 48'hC0C0_C0C0_C0C0; desc_ethertype = 16'h0003;
    port_ack = 1'b1;
    tick();
    desc_valid = 1'b0; port_ack = 1'b0;
    chk("pp_level", lvl, 2);
    chk("pp_dst_head", dst, 48'hA0A0_A0A0_A0A0);
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1; tick();
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    chk("pp_frames", frm, 1);
    run_frame(48'hB0B0_B0B0_B0B0, 16'h0002, 2, 1, 2, w);
    chk("pp_gap_cycles", w, 13);
    run_frame(48'hC0C0_C0C0_C0C0, 16'h0003, 2, 0, 3, w);
    repeat (15) tick();

    // Asynchronous reset while busy with two queued
    push(48'h0101_0101_0101, 16'h0101);
    push(48'h0202_0202_0202, 16'h0202);
    push(48'h0303_0303_0303, 16'h0303);
    port_ack = 1'b1; tick(); port_ack = 1'b0;
    chk("pre_rst_busy", {63'd0, busy}, 1);
    chk("pre_rst_level", lvl, 2);
    #2 areset = 1'b1;
    #1;
    chk("arst_req", {63'd0, req}, 0);
    chk("arst_busy", {63'd0, busy}, 0);
    chk("arst_level", lvl, 0);
    chk("arst_frames", frm, 0);
    chk("arst_lat", lat, 0);
    chk("arst_dst", dst, 0);
    chk("arst_type", typ, 0);
    chk("arst_ready", {63'd0, ready}, 1);
    #1 areset = 1'b0;
    tick();
    port_ack = 1'b1; tick(); port_ack = 1'b0;
    repeat (20) tick();
    chk("post_rst_busy", {63'd0, busy}, 0);
    chk("post_rst_req", {63'd0, req}, 0);
    chk("post_rst_frames", frm, 0);
    chk("post_rst_lat", lat, 0);

    // Latency saturation and frame counter wrap
    do_reset();
    force dut.r_frames_sent = 32'hFFFF_FFFF;
    #2 release dut.r_frames_sent;
    tick();
    chk("frames_preset", frm, 32'hFFFF_FFFF);
    push(48'h0A0B_0C0D_0E0F, 16'h0800);
    run_frame(48'h0A0B_0C0D_0E0F, 16'h0800, 70000, 0, 32'h0, w);
    chk("lat_saturated", lat, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
